// File: rtl/core_pkg.sv
// Shared fetch-side constants and the {pc, insn} record handed from fetch to decode.
package core_pkg;
  localparam int          CORE_AWIDTH      = 32;
  localparam int          CORE_DWIDTH      = 32;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [CORE_AWIDTH-1:0] pc;
    logic [CORE_DWIDTH-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: valid/ready request channel, in-order response channel.
interface fetch_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] addr;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;

  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear; storage is not reset, only pointers/count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, issues credit-limited imem reads,
// buffers in-order responses and discards wrong-path ones after a redirect.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] PC_RESET  = AWIDTH'(PC_RESET_DEFAULT),
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_if,
  input  logic              ifid_wren,
  input  logic              ifid_flush,
  input  logic              br_taken,
  input  logic [AWIDTH-1:0] br_target,
  fetch_unit_if.master      imem,
  output logic [AWIDTH-1:0] f_pc,
  output logic [AWIDTH-1:0] d_pc,
  output logic [DWIDTH-1:0] d_insn,
  output logic              d_valid
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [CW-1:0]            inf_cnt, buf_cnt, drop_cnt;
  logic                     inf_full, inf_empty, buf_full, buf_empty;
  logic [AWIDTH-1:0]        inf_pc;
  logic [AWIDTH+DWIDTH-1:0] buf_head;
  logic [CW:0]              occupancy;
  logic                     req_fire, rsp_pop, rsp_drop, rsp_keep, buf_pop;

  // Slots freed by decode this cycle count as available, so a 1-cycle memory streams.
  assign buf_pop   = ifid_wren && !ifid_flush && !buf_empty;
  assign occupancy = {1'b0, inf_cnt} + {1'b0, buf_cnt} - (CW+1)'(buf_pop);

  assign imem.req_valid = reset_n && !stall_if && !br_taken && !inf_full &&
                          (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem.addr      = f_pc;
  assign req_fire       = imem.req_valid && imem.req_ready;

  assign rsp_pop  = imem.rsp_valid && !inf_empty;
  assign rsp_drop = rsp_pop && (br_taken || (drop_cnt != '0));
  assign rsp_keep = rsp_pop && !rsp_drop && (!buf_full || buf_pop);

  fetch_fifo #(.WIDTH(AWIDTH), .DEPTH(BUF_DEPTH)) u_inflight (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .push  (req_fire),
    .pop   (rsp_pop),
    .wdata (f_pc),
    .rdata (inf_pc),
    .count (inf_cnt),
    .full  (inf_full),
    .empty (inf_empty)
  );

  fetch_fifo #(.WIDTH(AWIDTH + DWIDTH), .DEPTH(BUF_DEPTH)) u_rsp_buf (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (br_taken),
    .push  (rsp_keep),
    .pop   (buf_pop),
    .wdata ({inf_pc, imem.rsp_data}),
    .rdata (buf_head),
    .count (buf_cnt),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Fetch PC and wrong-path drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_pc     <= PC_RESET;
      drop_cnt <= '0;
    end else begin
      if (br_taken)      f_pc <= br_target;
      else if (req_fire) f_pc <= f_pc + AWIDTH'(4);

      // Everything still outstanding after this edge belongs to the old path.
      if (br_taken)                     drop_cnt <= inf_cnt - CW'(rsp_pop);
      else if (rsp_pop && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_insn  <= DWIDTH'(NOP_INSN);
    end else if (ifid_flush || (ifid_wren && buf_empty)) begin
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_insn  <= DWIDTH'(NOP_INSN);
    end else if (ifid_wren) begin
      d_valid <= 1'b1;
      d_pc    <= buf_head[AWIDTH+DWIDTH-1:DWIDTH];
      d_insn  <= buf_head[DWIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] P   = 32'h0100_0000;
  localparam logic [31:0] T   = 32'h0100_0100;
  localparam logic [31:0] KEY = 32'h5A5A_5A5A;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_if = 1'b0, ifid_wren = 1'b0, ifid_flush = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] f_pc, d_pc, d_insn;
  logic        d_valid;

  int errors = 0;
  int checks = 0;

  fetch_unit_if #(.AWIDTH(32), .DWIDTH(32)) imem ();

  fetch_unit #(.AWIDTH(32), .DWIDTH(32), .PC_RESET(P), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_if   (stall_if),
    .ifid_wren  (ifid_wren),
    .ifid_flush (ifid_flush),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem       (imem),
    .f_pc       (f_pc),
    .d_pc       (d_pc),
    .d_insn     (d_insn),
    .d_valid    (d_valid)
  );

  always #5 clk = ~clk;

  // Memory: responds lat cycles after the handshake with addr ^ KEY; reset with the core.
  logic        ready = 1'b1;
  int          lat = 1;
  logic [3:0]  sv;
  logic [31:0] sa [4];
  int          outst, max_outst = 0;

  assign imem.req_ready = ready;
  assign imem.rsp_valid = sv[lat-1];
  assign imem.rsp_data  = sa[lat-1] ^ KEY;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sv    <= '0;
      outst <= 0;
    end else begin
      sv    <= {sv[2:0], imem.req_valid && ready};
      sa[0] <= imem.addr;
      sa[1] <= sa[0];
      sa[2] <= sa[1];
      sa[3] <= sa[2];
      outst <= outst + int'(imem.req_valid && ready) - int'(imem.rsp_valid);
    end
  end

  always @(negedge clk) if (outst > max_outst) max_outst = outst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " f_pc"}, f_pc, P);
    chk({name, " req_valid"}, 32'(imem.req_valid), 32'd0);
    chk({name, " d_valid"}, 32'(d_valid), 32'd0);
    chk({name, " d_pc"}, d_pc, 32'd0);
    chk({name, " d_insn"}, d_insn, NOP);
  endtask

  // Each d_valid cycle must present the next sequential instruction, starting at first.
  task automatic expect_seq(input string name, input logic [31:0] first, input int n,
                            input int budget);
    logic [31:0] nxt;
    int          got;
    nxt = first;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (d_valid) begin
        chk({name, " d_pc"}, d_pc, nxt);
        chk({name, " d_insn"}, d_insn, nxt ^ KEY);
        nxt = nxt + 32'd4;
        got++;
      end
      @(posedge clk); #1;
    end
    chk({name, " count"}, 32'(got), 32'(n));
  endtask

  typedef struct {
    logic        stall, wren, flush;
    logic        exp_req;
    logic [31:0] exp_fpc;
    logic        exp_dv;
    logic [31:0] exp_dpc;
  } vec_t;

  vec_t vt [16];

  initial begin
    // startup stream, 3-cycle stall mid-stream, then flush+wren with a non-empty buffer
    vt[0]  = '{0, 1, 0, 1, P,         0, 32'd0};
    vt[1]  = '{0, 1, 0, 1, P + 32'd4,  0, 32'd0};
    vt[2]  = '{0, 1, 0, 1, P + 32'd8,  0, 32'd0};
    vt[3]  = '{0, 1, 0, 1, P + 32'd12, 1, P};
    vt[4]  = '{0, 1, 0, 1, P + 32'd16, 1, P + 32'd4};
    vt[5]  = '{1, 0, 0, 0, P + 32'd20, 1, P + 32'd8};
    vt[6]  = '{1, 0, 0, 0, P + 32'd20, 1, P + 32'd8};
    vt[7]  = '{1, 0, 0, 0, P + 32'd20, 1, P + 32'd8};
    vt[8]  = '{0, 1, 0, 1, P + 32'd20, 1, P + 32'd8};
    vt[9]  = '{0, 1, 0, 1, P + 32'd24, 1, P + 32'd12};
    vt[10] = '{0, 1, 0, 1, P + 32'd28, 1, P + 32'd16};
    vt[11] = '{0, 1, 0, 1, P + 32'd32, 1, P + 32'd20};
    vt[12] = '{0, 1, 1, 0, P + 32'd36, 1, P + 32'd24};
    vt[13] = '{0, 1, 0, 1, P + 32'd36, 0, 32'd0};
    vt[14] = '{0, 1, 0, 1, P + 32'd40, 1, P + 32'd28};
    vt[15] = '{0, 1, 0, 1, P + 32'd44, 1, P + 32'd32};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall_if   = vt[i].stall;
      ifid_wren  = vt[i].wren;
      ifid_flush = vt[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d req_valid", i), 32'(imem.req_valid), 32'(vt[i].exp_req));
      chk($sformatf("vec%0d f_pc", i), f_pc, vt[i].exp_fpc);
      chk($sformatf("vec%0d addr", i), imem.addr, vt[i].exp_fpc);
      chk($sformatf("vec%0d d_valid", i), 32'(d_valid), 32'(vt[i].exp_dv));
      chk($sformatf("vec%0d d_pc", i), d_pc, vt[i].exp_dpc);
      chk($sformatf("vec%0d d_insn", i), d_insn, vt[i].exp_dv ? (vt[i].exp_dpc ^ KEY) : NOP);
      @(posedge clk); #1;
    end
    stall_if   = 1'b0;
    ifid_flush = 1'b0;
    ifid_wren  = 1'b1;

    // memory refuses requests for 4 cycles: PC and address frozen
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("noready%0d f_pc", i), f_pc, P + 32'd48);
      chk($sformatf("noready%0d addr", i), imem.addr, P + 32'd48);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    expect_seq("noready resume", P + 32'd48, 3, 30);
    chk("outstanding bound", 32'(max_outst <= 2), 32'd1);

    // asynchronous reset mid-stream, then restart from the reset PC
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart req_valid", 32'(imem.req_valid), 32'd1);
    chk("restart f_pc", f_pc, P);
    @(posedge clk); #1;
    expect_seq("restart", P, 3, 30);

    // redirect with two requests in flight on a 3-cycle memory
    @(negedge clk); #2;
    reset_n = 1'b0;
    lat     = 3;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    br_taken  = 1'b1;
    br_target = T;
    @(negedge clk);
    chk("redirect outstanding", 32'(outst), 32'd2);
    chk("redirect req_valid", 32'(imem.req_valid), 32'd0);
    @(posedge clk); #1;
    br_taken = 1'b0;
    @(negedge clk);
    chk("redirect f_pc", f_pc, T);
    @(posedge clk); #1;
    expect_seq("redirect path", T, 3, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
